// File: rtl/adc_pkg.sv
// Shared widths and calibration state encoding for the ADC slice unfold block.
package adc_pkg;

  localparam int NADC     = 8;
  localparam int NAVG_MAX = 8;
  // Sign + magnitude + worst-case growth from summing 2^NAVG_MAX samples.
  localparam int ACC_W    = NADC + 1 + NAVG_MAX;

  typedef enum logic [1:0] {
    CAL_IDLE  = 2'd0,
    CAL_ACCUM = 2'd1,
    CAL_DONE  = 2'd2
  } cal_state_t;

endpackage

// File: rtl/adc_cal_avg.sv
// Calibration averager: sums 2^len unfolded samples and reports their floored mean.
module adc_cal_avg
  import adc_pkg::*;
#(
  parameter int Nadc     = NADC,
  parameter int Navg_max = NAVG_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v1,
  input  logic [Nadc:0] u,
  input  logic          cal_start,
  input  logic [3:0]    avg_len,
  output logic          cal_busy,
  output logic          cal_done,
  output logic [Nadc:0] cal_mean
);

  localparam int AW = Nadc + 1 + Navg_max;
  localparam int CW = Navg_max + 1;

  cal_state_t            state_r;
  logic signed [AW-1:0]  acc_r;
  logic signed [AW-1:0]  acc_sum_s;
  logic signed [AW-1:0]  acc_shift_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_inc_s;
  logic [CW-1:0]         cnt_target_s;
  logic [3:0]            len_r;
  logic [3:0]            len_clamp_s;
  logic                  last_s;

  // Next accumulator/counter values and run-completion detection.
  always_comb begin
    acc_sum_s    = acc_r + $signed({{(AW-Nadc-1){u[Nadc]}}, u});
    acc_shift_s  = acc_sum_s >>> len_r;
    cnt_inc_s    = cnt_r + CW'(1);
    cnt_target_s = CW'(1) << len_r;
    last_s       = (cnt_inc_s == cnt_target_s);
    if (avg_len > 4'(Navg_max)) begin
      len_clamp_s = 4'(Navg_max);
    end else begin
      len_clamp_s = avg_len;
    end
  end

  // Calibration FSM with registered status and mean outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= CAL_IDLE;
      acc_r    <= '0;
      cnt_r    <= '0;
      len_r    <= 4'd0;
      cal_busy <= 1'b0;
      cal_done <= 1'b0;
      cal_mean <= '0;
    end else begin
      case (state_r)
        CAL_IDLE, CAL_DONE: begin
          if (cal_start) begin
            state_r  <= CAL_ACCUM;
            acc_r    <= '0;
            cnt_r    <= '0;
            len_r    <= len_clamp_s;
            cal_busy <= 1'b1;
            cal_done <= 1'b0;
          end
        end
        CAL_ACCUM: begin
          // Start requests are deliberately ignored while a run is active.
          if (v1) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              state_r  <= CAL_DONE;
              cal_mean <= acc_shift_s[Nadc:0];
              cal_busy <= 1'b0;
              cal_done <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= CAL_IDLE;
          cal_busy <= 1'b0;
          cal_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_slice_unfold.sv
// Unfolds slice sign/magnitude into signed samples, removes offset with saturation,
// and feeds the calibration averager.
module adc_slice_unfold
  import adc_pkg::*;
#(
  parameter int Nadc     = NADC,
  parameter int Navg_max = NAVG_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sign_in,
  input  logic [Nadc-1:0] mag_in,
  input  logic [Nadc:0] offset,
  input  logic [3:0]    avg_len,
  input  logic          cal_start,
  output logic [Nadc:0] data_out,
  output logic          valid_out,
  output logic          cal_busy,
  output logic          cal_done,
  output logic [Nadc:0] cal_mean
);

  logic [Nadc:0]   u_r;
  logic            v1_r;
  logic [Nadc:0]   mag_ext_s;
  logic [Nadc:0]   u_next_s;
  logic [Nadc+1:0] diff_s;
  logic [Nadc:0]   sat_s;

  // Unfold and offset-correct; one extra bit keeps the difference exact before clamping.
  always_comb begin
    mag_ext_s = {1'b0, mag_in};
    if (sign_in) begin
      u_next_s = mag_ext_s;
    end else begin
      u_next_s = (Nadc+1)'(0) - mag_ext_s;
    end
    diff_s = {u_r[Nadc], u_r} - {offset[Nadc], offset};
    if (diff_s[Nadc+1] != diff_s[Nadc]) begin
      sat_s = diff_s[Nadc+1] ? {1'b1, {Nadc{1'b0}}} : {1'b0, {Nadc{1'b1}}};
    end else begin
      sat_s = diff_s[Nadc:0];
    end
  end

  // Two-stage unfold/offset pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_r       <= '0;
      v1_r      <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      v1_r      <= en;
      valid_out <= v1_r;
      if (en) begin
        u_r <= u_next_s;
      end
      if (v1_r) begin
        data_out <= sat_s;
      end
    end
  end

  adc_cal_avg #(
    .Nadc     (Nadc),
    .Navg_max (Navg_max)
  ) u_cal_avg (
    .clk       (clk),
    .rst       (rst),
    .v1        (v1_r),
    .u         (u_r),
    .cal_start (cal_start),
    .avg_len   (avg_len),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_mean  (cal_mean)
  );

endmodule

// File: tb/tb_adc_slice_unfold.sv
// Randomized and directed bench for adc_slice_unfold against an integer reference model.
module tb_adc_slice_unfold;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sign_in;
  logic [7:0] mag_in;
  logic [8:0] offset;
  logic [3:0] avg_len;
  logic       cal_start;
  logic [8:0] data_out;
  logic       valid_out;
  logic       cal_busy;
  logic       cal_done;
  logic [8:0] cal_mean;

  int checks = 0;
  int errors = 0;

  // Reference model state, all plain integers.
  bit m_s1_v, m_valid;
  int m_s1_u, m_data;
  bit m_busy, m_done;
  int m_mean, m_sum, m_n, m_target;

  adc_slice_unfold dut (
    .clk(clk), .rst(rst), .en(en), .sign_in(sign_in), .mag_in(mag_in),
    .offset(offset), .avg_len(avg_len), .cal_start(cal_start),
    .data_out(data_out), .valid_out(valid_out), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_mean(cal_mean)
  );

  always #5 clk = ~clk;

  function automatic int sat9(input int d);
    if (d > 255) return 255;
    if (d < -256) return -256;
    return d;
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1_v = 0; m_s1_u = 0; m_valid = 0; m_data = 0;
    m_busy = 0; m_done = 0; m_mean = 0; m_sum = 0; m_n = 0; m_target = 1;
  endtask

  // Applies one rising edge worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    int len;
    bit v1_prev;
    int u_prev;
    v1_prev = m_s1_v;
    u_prev  = m_s1_u;
    if (v1_prev) m_data = sat9(u_prev - $signed(offset));
    m_valid = v1_prev;
    m_s1_v  = en;
    if (en) m_s1_u = sign_in ? int'(mag_in) : -int'(mag_in);
    if (!m_busy && cal_start) begin
      len = (avg_len > 4'd8) ? 8 : int'(avg_len);
      m_busy = 1; m_done = 0; m_sum = 0; m_n = 0; m_target = 1 << len;
    end else if (m_busy && v1_prev) begin
      m_sum += u_prev;
      m_n++;
      if (m_n == m_target) begin
        m_busy = 0; m_done = 1; m_mean = floor_div(m_sum, m_n);
      end
    end
  endtask

  task automatic compare_all();
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("data_out", int'($signed(data_out)), m_data);
    chk("cal_busy", int'(cal_busy), int'(m_busy));
    chk("cal_done", int'(cal_done), int'(m_done));
    chk("cal_mean", int'($signed(cal_mean)), m_mean);
  endtask

  task automatic step(input bit e, input bit s, input int m, input bit cs);
    en = e; sign_in = s; mag_in = m[7:0]; cal_start = cs;
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0; cal_start = 1'b0;
  endtask

  task automatic smp(input int v);
    step(1'b1, v >= 0, (v < 0) ? -v : v, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sign_in = 1'b0; mag_in = 8'd0;
    offset = 9'd0; avg_len = 4'd0; cal_start = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic unfold latency.
    step(1'b1, 1'b1, 100, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_valid_c2", int'(valid_out), 1);
    chk("lit_data_100", int'($signed(data_out)), 100);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_valid_drop", int'(valid_out), 0);
    chk("lit_data_hold", int'($signed(data_out)), 100);

    // Saturation at both rails.
    offset = 9'd10;
    step(1'b1, 1'b0, 255, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_sat_neg", int'($signed(data_out)), -256);
    offset = 9'h1FB;
    step(1'b1, 1'b1, 255, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_sat_pos", int'($signed(data_out)), 255);
    offset = 9'd0;

    // Four-sample average.
    avg_len = 4'd2;
    step(1'b0, 1'b0, 0, 1'b1);
    chk("lit_busy_start", int'(cal_busy), 1);
    smp(10); smp(11); smp(-4); smp(7);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_done4", int'(cal_done), 1);
    chk("lit_mean6", int'($signed(cal_mean)), 6);
    chk("lit_model_mean6", m_mean, 6);
    repeat (3) step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_done_hold", int'(cal_done), 1);

    // Floor of a negative mean, with an enable gap mid-run.
    avg_len = 4'd1;
    step(1'b0, 1'b0, 0, 1'b1);
    smp(-3);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_busy_gap", int'(cal_busy), 1);
    smp(-2);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_mean_m3", int'($signed(cal_mean)), -3);

    // Reset mid-run, then a fresh one-sample run.
    avg_len = 4'd3;
    step(1'b0, 1'b0, 0, 1'b1);
    smp(40); smp(50);
    pulse_reset();
    chk("lit_rst_busy", int'(cal_busy), 0);
    repeat (12) step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_no_done", int'(cal_done), 0);
    avg_len = 4'd0;
    step(1'b0, 1'b0, 0, 1'b1);
    smp(5);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_mean5", int'($signed(cal_mean)), 5);

    // Start coincident with a valid sample, plus a start during the run.
    avg_len = 4'd1;
    smp(50);
    step(1'b1, 1'b1, 20, 1'b1);
    step(1'b1, 1'b1, 30, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("lit_mean25", int'($signed(cal_mean)), 25);

    // Randomized traffic, including out-of-range lengths and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 15) == 0) offset = 9'($urandom);
      if ($urandom_range(0, 7) == 0) avg_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1499) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom),
           ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)),
           $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
